// File: rtl/and2_result_skid.sv
// Two-entry valid/ready skid stage for the AND wrapper result, with a delivered-result counter.
// Upstream ready depends on registered state only, so no combinational path crosses the stage.
module and2_result_skid #(
    parameter int WIDTH     = 2,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 CLK,
    input  logic                 ASYNCRESET,
    input  logic [WIDTH-1:0]     I,
    input  logic                 I_valid,
    output logic                 I_ready,
    output logic [WIDTH-1:0]     O,
    output logic                 O_valid,
    input  logic                 O_ready,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_main;
    logic [WIDTH-1:0]     r_skid;
    logic [CNT_WIDTH-1:0] r_count;

    logic w_accept;
    logic w_deliver;

    assign O_valid   = (r_state != S_EMPTY);
    assign I_ready   = (r_state != S_FULL);
    assign O         = r_main;
    assign count     = r_count;
    assign w_accept  = I_valid & I_ready;
    assign w_deliver = O_valid & O_ready;

    // NOTE: the two data registers are reset as well as the state, so O reads 0 after reset.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every branch reading the pre-edge state.
            case (r_state)
                S_EMPTY: begin
                    if (w_accept) begin
                        r_main  <= I;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_accept && w_deliver) begin
                        r_main <= I;
                    end else if (w_accept) begin
                        r_skid  <= I;
                        r_state <= S_FULL;
                    end else if (w_deliver) begin
                        r_state <= S_EMPTY;
                    end
                end
                S_FULL: begin
                    // No accept can happen here because I_ready is low.
                    if (w_deliver) begin
                        r_main  <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

    // clr takes priority over a simultaneous deliver.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (w_deliver) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule
